// File: rtl/dp_rr_scheduler_if.sv
// Requester and datapath signal bundle for dp_rr_scheduler.
// The scheduler connects through the slave modport; stimulus, requesters and
// the shared datapath model connect through the master modport.
interface dp_rr_scheduler_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4
);

   // Requester side
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;

   // Shared datapath side
   logic                  dp_valid;
   logic [WIDTH-1:0]      dp_data_in;
   logic                  dp_done;
   logic [WIDTH-1:0]      dp_data_out;

   // Status
   logic                  busy;

   modport master (
      output req_valid,
      output req_data,
      output dp_done,
      output dp_data_out,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_err,
      input  dp_valid,
      input  dp_data_in,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  dp_done,
      input  dp_data_out,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output rsp_err,
      output dp_valid,
      output dp_data_in,
      output busy
   );

endinterface

// File: rtl/dp_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit datapath between NREQ requesters.
// Each transaction: accept one operand in IDLE, pulse dp_valid in ISSUE, wait
// for dp_done (bounded by TIMEOUT cycles) in WAIT, pulse rsp_valid in RESP.
module dp_rr_scheduler #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk_p,
   input  logic              rst,
   dp_rr_scheduler_if.slave  bus
);

   localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SumW = PtrW + 1;
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [PtrW-1:0] PtrLast = PtrW'(NREQ - 1);
   localparam logic [SumW-1:0] NreqSum = SumW'(NREQ);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0]  grant_q, grant_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;

   logic             any_valid;
   logic             accept;
   logic [PtrW-1:0]  winner;
   logic [SumW-1:0]  cand_sum;
   logic [PtrW-1:0]  cand;
   logic [NREQ-1:0]  winner_oh;
   logic [NREQ-1:0]  grant_oh;

   // First valid requester searching upward from rr_ptr, wrapping at NREQ.
   always_comb begin
      any_valid = 1'b0;
      winner    = rr_ptr_q;
      cand_sum  = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + SumW'(k);
         if (cand_sum >= NreqSum) begin
            cand_sum = cand_sum - NreqSum;
         end
         cand = cand_sum[PtrW-1:0];
         if (!any_valid && bus.req_valid[cand]) begin
            any_valid = 1'b1;
            winner    = cand;
         end
      end
   end

   // One-hot decodes of the arbitration winner and the latched grant.
   always_comb begin
      winner_oh         = '0;
      winner_oh[winner] = 1'b1;
      grant_oh          = '0;
      grant_oh[grant_q] = 1'b1;
   end

   // Reset wins over an accept, so req_ready is suppressed while rst is high.
   assign accept = (state_q == StIdle) && any_valid && !rst;

   // Transaction sequencing: next state, latched operand/result and timeout count.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      operand_d  = operand_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      wait_cnt_d = wait_cnt_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               grant_d   = winner;
               operand_d = bus.req_data[winner * WIDTH +: WIDTH];
               state_d   = StIssue;
            end
         end

         StIssue: begin
            // dp_done is deliberately not looked at here.
            wait_cnt_d = '0;
            state_d    = StWait;
         end

         StWait: begin
            if (bus.dp_done) begin
               // Done beats a timeout landing on the same edge.
               rsp_data_d = bus.dp_data_out;
               rsp_err_d  = 1'b0;
               state_d    = StResp;
            end else if (wait_cnt_q == CntLast) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = StResp;
            end else begin
               // Never reaches past CntLast, so the counter cannot wrap.
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         StResp: begin
            rr_ptr_d = (grant_q == PtrLast) ? '0 : grant_q + 1'b1;
            state_d  = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk_p) begin
      if (rst) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         operand_q  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         operand_q  <= operand_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Moore outputs decoded from state; only req_ready looks at live inputs.
   assign bus.req_ready  = accept ? winner_oh : '0;
   assign bus.rsp_valid  = (state_q == StResp) ? grant_oh : '0;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.dp_valid   = (state_q == StIssue);
   assign bus.dp_data_in = operand_q;
   assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Self-checking bench for dp_rr_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all cross-checked every cycle against
// a timestamp-based transaction model.
module tb_dp_rr_scheduler;

   localparam int WIDTH   = 8;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   logic clk_p = 1'b0;
   logic rst;

   always #5 clk_p = ~clk_p;

   dp_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   dp_rr_scheduler #(
      .WIDTH   (WIDTH),
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_p (clk_p),
      .rst   (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Transaction model: one in-flight transaction described by its accept cycle
   // m_t and response cycle m_r (-1 until done or timeout decides it).
   // ISSUE is cycle m_t+1, WAIT spans m_t+2 .. m_t+1+TIMEOUT, RESP is m_r.
   // ---------------------------------------------------------------------------
   bit             m_busy = 1'b0;
   int             m_t    = 0;
   int             m_r    = -1;
   int             m_win  = 0;
   int             m_ptr  = 0;
   logic [WIDTH-1:0] m_op  = '0;
   logic [WIDTH-1:0] m_res = '0;
   logic             m_err = 1'b0;

   task automatic model_cycle();
      int first;
      int idx;
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_rspv;
      first = -1;
      if (!m_busy && rst !== 1'b1) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (first < 0 && bus.req_valid[idx] === 1'b1) first = idx;
         end
      end
      exp_ready = '0;
      if (first >= 0) exp_ready[first] = 1'b1;
      exp_rspv = '0;
      if (m_busy && cyc == m_r) exp_rspv[m_win] = 1'b1;

      if (chk_en) begin
         chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("dp_valid", 32'(bus.dp_valid), 32'(m_busy && cyc == m_t + 1));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rspv));
         if (exp_rspv != '0) begin
            chk("rsp_data", 32'(bus.rsp_data), 32'(m_res));
            chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
         end
         if (m_busy && cyc > m_t && (m_r < 0 || cyc < m_r))
            chk("dp_data_in", 32'(bus.dp_data_in), 32'(m_op));
      end

      // Advance to what the coming rising edge must produce.
      if (rst === 1'b1) begin
         m_busy = 1'b0;
         m_ptr  = 0;
         m_r    = -1;
      end else if (!m_busy) begin
         if (first >= 0) begin
            m_busy = 1'b1;
            m_t    = cyc;
            m_r    = -1;
            m_win  = first;
            m_op   = bus.req_data[first*WIDTH +: WIDTH];
         end
      end else if (cyc == m_r) begin
         m_busy = 1'b0;
         m_ptr  = (m_win + 1) % NREQ;
      end else if (m_r < 0 && cyc >= m_t + 2) begin
         if (bus.dp_done === 1'b1) begin
            m_r   = cyc + 1;
            m_res = bus.dp_data_out;
            m_err = 1'b0;
         end else if (cyc == m_t + 1 + TIMEOUT) begin
            m_r   = cyc + 1;
            m_res = '0;
            m_err = 1'b1;
         end
      end
   endtask

   // Compare process: outputs sampled on the falling edge, every cycle.
   initial begin
      forever begin
         @(negedge clk_p);
         model_cycle();
         cyc++;
      end
   end

   // ---------------------------------------------------------------------------
   // Directed helpers
   // ---------------------------------------------------------------------------
   task automatic next_cycle();
      @(posedge clk_p);
      #1;
   endtask

   // Expect requester w to win with operand op; done_at is the cycle offset
   // after dp_valid on which dp_done rises (-1: never).
   task automatic run_txn(input int w, input logic [WIDTH-1:0] op, input bit issue_done,
                          input int done_at, input logic [WIDTH-1:0] res,
                          input logic [NREQ-1:0] drop);
      int n;
      int k;
      bit exp_err;
      logic [NREQ-1:0] oh;
      oh      = '0;
      oh[w]   = 1'b1;
      exp_err = !(done_at >= 1 && done_at <= TIMEOUT);
      n = 0;
      @(negedge clk_p);
      while (bus.req_ready == '0 && n < 40) begin
         @(negedge clk_p);
         n++;
      end
      chk("txn_grant", 32'(bus.req_ready), 32'(oh));
      next_cycle();
      bus.req_valid   = bus.req_valid & ~drop;
      bus.dp_done     = issue_done;
      bus.dp_data_out = 8'hEE;
      @(negedge clk_p);
      chk("txn_dp_valid", 32'(bus.dp_valid), 32'd1);
      chk("txn_operand", 32'(bus.dp_data_in), 32'(op));
      k = 0;
      do begin
         next_cycle();
         k++;
         bus.dp_done     = (k == done_at);
         bus.dp_data_out = (k == done_at) ? res : 8'($urandom);
         @(negedge clk_p);
      end while (bus.rsp_valid == '0 && k < 40);
      chk("txn_latency", 32'(k), exp_err ? 32'(TIMEOUT + 1) : 32'(done_at + 1));
      chk("txn_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      chk("txn_rsp_data", 32'(bus.rsp_data), exp_err ? 32'd0 : 32'(res));
      chk("txn_rsp_err", 32'(bus.rsp_err), 32'(exp_err));
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [NREQ-1:0] acc;
      rst             = 1'b1;
      bus.req_valid   = 4'b1111;
      bus.req_data    = {8'd4, 8'd3, 8'd2, 8'd1};
      bus.dp_done     = 1'b0;
      bus.dp_data_out = '0;

      // Reset held for two edges with every requester asking.
      next_cycle();
      chk_en = 1'b1;
      @(negedge clk_p);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_dp_valid", 32'(bus.dp_valid), 32'd0);
      chk("rst_dp_data_in", 32'(bus.dp_data_in), 32'd0);
      next_cycle();
      rst = 1'b0;

      // Round-robin with all four holding: 0,1,2,3,0; result = 2 * operand.
      run_txn(0, 8'd1, 1'b0, 2, 8'd2, 4'b0000);
      run_txn(1, 8'd2, 1'b0, 2, 8'd4, 4'b0000);
      run_txn(2, 8'd3, 1'b0, 2, 8'd6, 4'b0000);
      run_txn(3, 8'd4, 1'b0, 2, 8'd8, 4'b0000);
      run_txn(0, 8'd1, 1'b0, 2, 8'd2, 4'b1111);

      // Single request from requester 2.
      next_cycle();
      bus.req_valid = 4'b0100;
      bus.req_data[23:16] = 8'd8;
      run_txn(2, 8'd8, 1'b0, 2, 8'd16, 4'b0100);

      // Timeout: dp_done never arrives.
      next_cycle();
      bus.req_valid = 4'b0001;
      bus.req_data[7:0] = 8'h55;
      run_txn(0, 8'h55, 1'b0, -1, 8'h00, 4'b0001);

      // dp_done on ISSUE ignored; dp_done on the timeout edge wins.
      next_cycle();
      bus.req_valid = 4'b1000;
      bus.req_data[31:24] = 8'h33;
      run_txn(3, 8'h33, 1'b1, TIMEOUT, 8'hA5, 4'b1000);

      // Stray dp_done while idle.
      next_cycle();
      bus.dp_done     = 1'b1;
      bus.dp_data_out = 8'h77;
      next_cycle();
      bus.dp_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_p);
         chk("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("stray_busy", 32'(bus.busy), 32'd0);
      end

      // Move the pointer to 2 via a transaction from requester 1.
      next_cycle();
      bus.req_valid = 4'b0010;
      bus.req_data[15:8] = 8'h22;
      run_txn(1, 8'h22, 1'b0, 3, 8'h99, 4'b0010);

      // Mid-WAIT reset: requester 2 wins, is abandoned, then 1 wins from pointer 0.
      next_cycle();
      bus.req_valid = 4'b0110;
      bus.req_data[15:8]  = 8'h11;
      bus.req_data[23:16] = 8'h66;
      @(negedge clk_p);
      chk("mid_grant", 32'(bus.req_ready), 32'b0100);
      next_cycle();
      next_cycle();
      next_cycle();
      rst = 1'b1;
      @(negedge clk_p);
      chk("mid_busy_before", 32'(bus.busy), 32'd1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk_p);
      chk("mid_busy_after", 32'(bus.busy), 32'd0);
      chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_regrant", 32'(bus.req_ready), 32'b0010);
      next_cycle();
      bus.req_valid = 4'b0100;

      // Randomized traffic; the model checks every cycle.
      repeat (3000) begin
         @(negedge clk_p);
         acc = (rst === 1'b1) ? '0 : (bus.req_valid & bus.req_ready);
         next_cycle();
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
               if ($urandom_range(0, 1) == 0) bus.req_valid[i] = 1'b0;
               else bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom);
            end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
               bus.req_valid[i] = 1'b1;
               bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom);
            end
         end
         bus.dp_done     = ($urandom_range(0, 7) == 0);
         bus.dp_data_out = 8'($urandom);
      end

      @(negedge clk_p);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time bound in case anything stalls.
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: run did not complete, got no finish, expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dp_rr_scheduler.md
Name: dp_rr_scheduler

Overview:
- Shares one WIDTH-bit processing datapath between NREQ requesters.
- Arbitrates round-robin and issues one operand per transaction to the datapath with a single-cycle start pulse.
- Waits for the datapath done pulse, with a timeout, then returns the result to the winning requester.
- Sits between stimulus/requester blocks and the shared data_in/data_out datapath.

Parameters:
- WIDTH, 8, operand and result width.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, max cycles in WAIT before the transaction is aborted with an error (≥2).

Ports:
- clk_p  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid; held until accepted.
- req_data  in  NREQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept; request i is accepted when req_valid[i] & req_ready[i] at a rising edge.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the granted requester.
- rsp_data  out  WIDTH  result; valid only while any rsp_valid bit is set.
- rsp_err  out  1  timeout flag; qualified by rsp_valid.
- dp_valid  out  1  one-cycle start pulse to the datapath.
- dp_data_in  out  WIDTH  latched operand; stable from the ISSUE cycle through the end of WAIT.
- dp_done  in  1  datapath completion pulse.
- dp_data_out  in  WIDTH  datapath result; sampled when dp_done is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (the cycle after rst is sampled high): state=IDLE, rr_ptr=0, grant=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, dp_valid=0, dp_data_in=0, wait_cnt=0, busy=0.
- rst mid-transaction: the transaction is abandoned, no rsp_valid is issued, and the next arbitration starts from requester 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. Outputs are Moore-style, except req_ready.
- IDLE:
  - winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = onehot(winner) combinationally, only in IDLE and only if any req_valid is set.
  - On the accept edge: latch grant=winner, latch dp_data_in=req_data[winner], go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - dp_valid=1 for exactly one cycle; wait_cnt cleared; go to WAIT.
  - dp_done is ignored in this cycle.
- WAIT:
  - dp_done=1: latch rsp_data=dp_data_out, rsp_err=0, go to RESP.
  - Otherwise wait_cnt increments. At wait_cnt==TIMEOUT-1 without done: latch rsp_data=0, rsp_err=1, go to RESP.
  - dp_done on the same edge as the timeout: done wins, rsp_err=0.
  - dp_done arriving in any state other than WAIT is ignored.
- RESP:
  - rsp_valid[grant]=1 for one cycle.
  - rr_ptr=(grant+1) mod NREQ.
  - Go to IDLE. No new accept occurs in this cycle.
- Latency:
  - accept edge → dp_valid: 1 cycle.
  - dp_done edge → rsp_valid: 1 cycle.
  - Minimum transaction length (accept to return to IDLE): 4 cycles.
- Fairness:
  - A requester that keeps req_valid high is served within NREQ transactions.
  - The winner's req_valid may drop after accept without effect.
  - Non-winners stay unaccepted; their req_valid and req_data must be held stable.
- wait_cnt width = clog2(TIMEOUT); it saturates and never wraps.

Test Plan:
- Reset: rst high for 2 cycles while req_valid=4'b1111 → all outputs 0. First grant after rst falls goes to requester 0.
- Single request: req 2 with operand 8'd8; datapath returns 8'd16 two cycles after dp_valid → dp_data_in=8'd8, dp_valid one pulse, rsp_valid=4'b0100, rsp_data=8'd16, rsp_err=0.
- Round-robin: all 4 requesters hold valid with operands 8'd1..8'd4 → grant order 0,1,2,3,0. Each rsp_data matches its own operand's result. Every rsp_valid is one-hot.
- Timeout: dp_done never asserted, TIMEOUT=16 → rsp_valid on the granted requester with rsp_err=1, rsp_data=0, 17 cycles after dp_valid. The next request proceeds normally.
- Boundary events:
  - dp_done on the ISSUE cycle is ignored.
  - dp_done coinciding with the timeout edge gives rsp_err=0.
  - Stray dp_done in IDLE causes no rsp_valid.
- Mid-op reset: rst asserted during WAIT → no rsp_valid, busy=0 next cycle. The pending requester is re-granted from rr_ptr=0.
